// File: rtl/glay_cu_control_pkg.sv
// -----------------------------------------------------------------------------
// Shared types for the GLAY control path.
//   GLAY_GLOBALS_PKG    : build-wide sizing constants (CU_COUNT_LOCAL).
//   GLAY_DESCRIPTOR_PKG : GLAYDescriptorInterface, the broadcast kernel
//                         descriptor (valid + payload).
//   GLAY_CONTROL_PKG    : control_cu_state, the per-cluster responder states.
// No ports; compile this file before any module that imports it.
// -----------------------------------------------------------------------------
package GLAY_GLOBALS_PKG;
   localparam int CU_COUNT_LOCAL = 4;
endpackage

package GLAY_DESCRIPTOR_PKG;
   localparam int GLAY_DESC_PAYLOAD_W = 32;

   typedef struct packed {
      logic                           valid;
      logic [GLAY_DESC_PAYLOAD_W-1:0] payload;
   } GLAYDescriptorInterface;
endpackage

package GLAY_CONTROL_PKG;
   typedef enum logic [2:0] {
      CU_SETUP,
      CU_IDLE,
      CU_START,
      CU_BUSY,
      CU_DONE
   } control_cu_state;
endpackage

// File: rtl/glay_cu_control.sv
// -----------------------------------------------------------------------------
// glay_cu_control - CU-side end of the kernel start/done handshake.
//
// After reset it holds glay_cu_setup_out high for SETUP_CYCLES cycles, then
// waits for the broadcast descriptor. On accept it latches the payload, pulses
// pe_start_out to every PE for one cycle, gathers PE done flags in a sticky
// vector and raises glay_cu_done_out once all PEs have reported. Done is held
// until the descriptor valid drops. Dropping valid mid-run aborts silently.
//
// Ports:
//   ap_clk, areset (async, active high)
//   glay_descriptor_in   broadcast descriptor from the kernel controller
//   glay_cu_setup_out    high while the post-reset setup window runs
//   glay_cu_done_out     cluster run complete
//   pe_descriptor_out    latched descriptor fanned out to the PEs
//   pe_start_out         one-cycle start pulse per PE
//   pe_done_in           per-PE done (pulse or level)
//   cu_busy_cycles_out   cycles spent in START+BUSY for the last run
//
// Optional feature: define GLAY_CU_CONTROL_PERF_COUNTER_EN to build the
// busy-cycle counter; otherwise cu_busy_cycles_out is tied to zero.
// -----------------------------------------------------------------------------
module glay_cu_control
   import GLAY_GLOBALS_PKG::*;
   import GLAY_DESCRIPTOR_PKG::*;
   import GLAY_CONTROL_PKG::*;
#(
   parameter int NUM_GRAPH_PE = CU_COUNT_LOCAL,
   parameter int SETUP_CYCLES = 16
) (
   input  logic                    ap_clk,
   input  logic                    areset,
   input  GLAYDescriptorInterface  glay_descriptor_in,
   output logic                    glay_cu_setup_out,
   output logic                    glay_cu_done_out,
   output GLAYDescriptorInterface  pe_descriptor_out,
   output logic [NUM_GRAPH_PE-1:0] pe_start_out,
   input  logic [NUM_GRAPH_PE-1:0] pe_done_in,
   output logic [31:0]             cu_busy_cycles_out
);

   localparam int CNT_W = $clog2(SETUP_CYCLES + 1);

   control_cu_state         state;
   logic [CNT_W-1:0]        setup_cnt;
   logic [NUM_GRAPH_PE-1:0] sticky;
   logic [NUM_GRAPH_PE-1:0] done_all;

   // Include this cycle's flags so the final done is not delayed a cycle.
   assign done_all = sticky | pe_done_in;

   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) begin
         state             <= CU_SETUP;
         setup_cnt         <= CNT_W'(SETUP_CYCLES);
         sticky            <= '0;
         glay_cu_setup_out <= 1'b1;
         glay_cu_done_out  <= 1'b0;
         pe_descriptor_out <= '0;
         pe_start_out      <= '0;
      end else begin
         case (state)
            CU_SETUP: begin
               setup_cnt <= setup_cnt - 1'b1;
               // Leave as the counter reaches zero so setup drops after
               // exactly SETUP_CYCLES edges.
               if (setup_cnt == CNT_W'(1)) begin
                  state             <= CU_IDLE;
                  glay_cu_setup_out <= 1'b0;
               end
            end
            CU_IDLE: begin
               if (glay_descriptor_in.valid) begin
                  pe_descriptor_out.payload <= glay_descriptor_in.payload;
                  pe_descriptor_out.valid   <= 1'b1;
                  pe_start_out              <= '1;
                  sticky                    <= '0;
                  state                     <= CU_START;
               end
            end
            CU_START: begin
               pe_start_out <= '0;
               if (!glay_descriptor_in.valid) begin
                  pe_descriptor_out.valid <= 1'b0;
                  state                   <= CU_IDLE;
               end else begin
                  // A PE may finish during the start cycle itself.
                  sticky <= pe_done_in;
                  state  <= CU_BUSY;
               end
            end
            CU_BUSY: begin
               // Abort wins over a coincident completion.
               if (!glay_descriptor_in.valid) begin
                  pe_descriptor_out.valid <= 1'b0;
                  state                   <= CU_IDLE;
               end else begin
                  sticky <= done_all;
                  if (&done_all) begin
                     glay_cu_done_out        <= 1'b1;
                     pe_descriptor_out.valid <= 1'b0;
                     state                   <= CU_DONE;
                  end
               end
            end
            CU_DONE: begin
               if (!glay_descriptor_in.valid) begin
                  glay_cu_done_out <= 1'b0;
                  state            <= CU_IDLE;
               end
            end
            default: state <= CU_SETUP;
         endcase
      end
   end

`ifdef GLAY_CU_CONTROL_PERF_COUNTER_EN
   always_ff @(posedge ap_clk or posedge areset) begin
      if (areset) begin
         cu_busy_cycles_out <= '0;
      end else if (state == CU_IDLE && glay_descriptor_in.valid) begin
         cu_busy_cycles_out <= '0;
      end else if ((state == CU_START || state == CU_BUSY) &&
                   (cu_busy_cycles_out != 32'hFFFF_FFFF)) begin
         cu_busy_cycles_out <= cu_busy_cycles_out + 32'd1;
      end
   end
`else
   assign cu_busy_cycles_out = '0;
`endif

endmodule

// File: tb/tb_glay_cu_control.sv
// -----------------------------------------------------------------------------
// Directed bench for glay_cu_control (NUM_GRAPH_PE=4, SETUP_CYCLES=16).
// Inputs change 1 time unit after a rising edge and are sampled by the next
// edge; outputs are checked 1 time unit after the edge that produced them.
// -----------------------------------------------------------------------------
module tb_glay_cu_control;
   import GLAY_DESCRIPTOR_PKG::*;

   localparam int NPE = 4;
`ifdef GLAY_CU_CONTROL_PERF_COUNTER_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic                   ap_clk = 1'b0;
   logic                   areset;
   GLAYDescriptorInterface desc_in;
   logic                   setup_o;
   logic                   done_o;
   GLAYDescriptorInterface pe_desc;
   logic [NPE-1:0]         start_o;
   logic [NPE-1:0]         pe_done;
   logic [31:0]            busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   glay_cu_control #(.NUM_GRAPH_PE(NPE), .SETUP_CYCLES(16)) dut (
      .ap_clk             (ap_clk),
      .areset             (areset),
      .glay_descriptor_in (desc_in),
      .glay_cu_setup_out  (setup_o),
      .glay_cu_done_out   (done_o),
      .pe_descriptor_out  (pe_desc),
      .pe_start_out       (start_o),
      .pe_done_in         (pe_done),
      .cu_busy_cycles_out (busy_o)
   );

   always #5 ap_clk = ~ap_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Expected busy count for the current build.
   function automatic logic [31:0] exp_busy(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   task automatic test_reset();
      areset  = 1'b1;
      desc_in = '0;
      pe_done = '0;
      repeat (3) @(posedge ap_clk);
      #1;
      n_checks++;
      if (setup_o !== 1'b1 || done_o !== 1'b0 || start_o !== 4'h0 ||
          pe_desc !== '0 || busy_o !== 32'd0) begin
         $display("FAIL reset_values: got setup=%b done=%b start=%h desc=%h busy=%0d required 1 0 0 0 0",
                  setup_o, done_o, start_o, pe_desc, busy_o);
         n_fail++;
      end
      areset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         // A valid pulse sampled during setup must be ignored.
         if (i == 3) desc_in.valid = 1'b1;
         if (i == 4) desc_in.valid = 1'b0;
         tick();
         n_checks++;
         if (setup_o !== (i < 15)) begin
            $display("FAIL setup_window edge %0d: got %b required %b", i, setup_o, (i < 15));
            n_fail++;
         end
         n_checks++;
         if (start_o !== 4'h0 || done_o !== 1'b0 || pe_desc.valid !== 1'b0) begin
            $display("FAIL setup_quiet edge %0d: got start=%h done=%b pev=%b required 0 0 0",
                     i, start_o, done_o, pe_desc.valid);
            n_fail++;
         end
      end
      repeat (2) tick();
      n_checks++;
      if (start_o !== 4'h0 || setup_o !== 1'b0) begin
         $display("FAIL idle_after_setup: got start=%h setup=%b required 0 0", start_o, setup_o);
         n_fail++;
      end
   endtask

   // Full run: dones at N+3 (PE0), N+5 (PE1,PE2), N+9 (PE3).
   task automatic test_run(input logic [31:0] pl);
      logic [NPE-1:0] pat;
      desc_in.valid   = 1'b1;
      desc_in.payload = pl;
      tick();                                   // edge N
      n_checks++;
      if (start_o !== 4'hF || pe_desc.valid !== 1'b1 || pe_desc.payload !== pl || done_o !== 1'b0) begin
         $display("FAIL run_accept: got start=%h pev=%b payload=%h done=%b required f 1 %h 0",
                  start_o, pe_desc.valid, pe_desc.payload, done_o, pl);
         n_fail++;
      end
      for (int e = 1; e <= 9; e++) begin
         pat = (e == 3) ? 4'b0001 : (e == 5) ? 4'b0110 : (e == 9) ? 4'b1000 : 4'b0000;
         pe_done = pat;
         tick();                                // edge N+e
         n_checks++;
         if (start_o !== 4'h0 || done_o !== (e == 9) || pe_desc.valid !== (e != 9)) begin
            $display("FAIL run_progress edge N+%0d: got start=%h done=%b pev=%b required 0 %b %b",
                     e, start_o, done_o, pe_desc.valid, (e == 9), (e != 9));
            n_fail++;
         end
      end
      pe_done = '0;
      n_checks++;
      if (busy_o !== exp_busy(9)) begin
         $display("FAIL run_busy_count: got %0d required %0d", busy_o, exp_busy(9));
         n_fail++;
      end
      desc_in.payload = 32'hDEAD_BEEF;          // must not disturb latched payload
      for (int h = 0; h < 3; h++) begin
         tick();
         n_checks++;
         if (done_o !== 1'b1 || pe_desc.payload !== pl) begin
            $display("FAIL done_hold %0d: got done=%b payload=%h required 1 %h", h, done_o, pe_desc.payload, pl);
            n_fail++;
         end
      end
      desc_in.valid = 1'b0;
      tick();                                   // edge K
      n_checks++;
      if (done_o !== 1'b0 || start_o !== 4'h0) begin
         $display("FAIL done_release: got done=%b start=%h required 0 0", done_o, start_o);
         n_fail++;
      end
      tick();
      n_checks++;
      if (busy_o !== exp_busy(9) || pe_desc.payload !== pl) begin
         $display("FAIL idle_hold: got busy=%0d payload=%h required %0d %h", busy_o, pe_desc.payload, exp_busy(9), pl);
         n_fail++;
      end
   endtask

   task automatic test_coincident();
      desc_in.valid   = 1'b1;
      desc_in.payload = 32'h11;
      tick();                                   // edge N
      pe_done = 4'hF;                           // concurrent with start
      tick();                                   // edge N+1
      pe_done = '0;
      n_checks++;
      if (done_o !== 1'b0) begin
         $display("FAIL coincident_early: got done=%b required 0", done_o);
         n_fail++;
      end
      tick();                                   // edge N+2
      n_checks++;
      if (done_o !== 1'b1 || busy_o !== exp_busy(2)) begin
         $display("FAIL coincident_done: got done=%b busy=%0d required 1 %0d", done_o, busy_o, exp_busy(2));
         n_fail++;
      end
      desc_in.valid = 1'b0;
      tick();
      n_checks++;
      if (done_o !== 1'b0) begin
         $display("FAIL coincident_release: got done=%b required 0", done_o);
         n_fail++;
      end
   endtask

   task automatic test_abort();
      desc_in.valid   = 1'b1;
      desc_in.payload = 32'h5A;
      tick();                                   // edge N
      pe_done = 4'b0001;
      tick();                                   // edge N+1
      pe_done = '0;
      tick();                                   // edge N+2 (BUSY)
      desc_in.valid = 1'b0;
      tick();                                   // edge N+3 abort
      n_checks++;
      if (done_o !== 1'b0 || pe_desc.valid !== 1'b0 || start_o !== 4'h0 || pe_desc.payload !== 32'h5A) begin
         $display("FAIL abort: got done=%b pev=%b start=%h payload=%h required 0 0 0 5a",
                  done_o, pe_desc.valid, start_o, pe_desc.payload);
         n_fail++;
      end
      repeat (2) tick();
      n_checks++;
      if (done_o !== 1'b0 || busy_o !== exp_busy(3)) begin
         $display("FAIL abort_idle: got done=%b busy=%0d required 0 %0d", done_o, busy_o, exp_busy(3));
         n_fail++;
      end
   endtask

   // Last done and valid drop sampled on the same edge: abort wins.
   task automatic test_abort_priority();
      desc_in.valid   = 1'b1;
      desc_in.payload = 32'h77;
      tick();                                   // edge N
      tick();                                   // edge N+1
      pe_done       = 4'hF;
      desc_in.valid = 1'b0;
      tick();                                   // edge N+2
      pe_done = '0;
      n_checks++;
      if (done_o !== 1'b0 || pe_desc.valid !== 1'b0) begin
         $display("FAIL abort_priority: got done=%b pev=%b required 0 0", done_o, pe_desc.valid);
         n_fail++;
      end
      tick();
      n_checks++;
      if (done_o !== 1'b0 || start_o !== 4'h0) begin
         $display("FAIL abort_priority_after: got done=%b start=%h required 0 0", done_o, start_o);
         n_fail++;
      end
   endtask

   task automatic test_reset_mid_busy();
      desc_in.valid   = 1'b1;
      desc_in.payload = 32'h42;
      repeat (3) tick();                        // into BUSY
      areset = 1'b1;
      #1;
      n_checks++;
      if (setup_o !== 1'b1 || done_o !== 1'b0 || start_o !== 4'h0 || pe_desc !== '0 || busy_o !== 32'd0) begin
         $display("FAIL reset_mid_busy: got setup=%b done=%b start=%h desc=%h busy=%0d required 1 0 0 0 0",
                  setup_o, done_o, start_o, pe_desc, busy_o);
         n_fail++;
      end
      desc_in.valid = 1'b0;
      tick();
      areset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         n_checks++;
         if (setup_o !== (i < 15) || done_o !== 1'b0) begin
            $display("FAIL resetup edge %0d: got setup=%b done=%b required %b 0", i, setup_o, done_o, (i < 15));
            n_fail++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_run(32'hA5);
      test_run(32'h3C);
      test_coincident();
      test_abort();
      test_abort_priority();
      test_reset_mid_busy();
      test_run(32'h99);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
